// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - asynchronous serial frame receiver (start, 8 data, parity, stop)
//
// Purpose: deserializes one 11-bit serial frame from rx into a parallel byte and
//          reports the received parity bit plus parity and framing verdicts.
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   rx       in   serial line, idle high, asynchronous to clk
//   data     out  [0:7] received byte, first wire bit in data[0]
//   par_bit  out  parity bit as received
//   par_err  out  parity mismatch against PAR_ODD
//   frm_err  out  stop bit sampled low
//   valid    out  one-cycle pulse when the outputs above are updated
//   busy     out  high whenever the FSM is not idle
module serial_frame_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PAR_ODD      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [0:7] data,
  output logic       par_bit,
  output logic       par_err,
  output logic       frm_err,
  output logic       valid,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  // First sample lands H cycles after the start edge; the counter counts down to 0.
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  logic            rx_meta;
  logic            rx_s;
  logic            rx_d;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [0:7]      data_sh;
  logic            par_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      data_sh <= '0;
      par_sh  <= 1'b0;
      data    <= '0;
      par_bit <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      valid   <= 1'b0;

      case (state)
        IDLE: begin
          // Falling edge only: a line stuck low never restarts reception.
          if (rx_d && !rx_s) begin
            state <= START;
            busy  <= 1'b1;
            cnt   <= HALF_LOAD;
          end
        end

        START: begin
          if (cnt == '0) begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
              idx   <= '0;
              cnt   <= BIT_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA: begin
          if (cnt == '0) begin
            data_sh[idx] <= rx_s;
            cnt          <= BIT_LOAD;
            if (idx == 3'd7) begin
              state <= PARITY;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        PARITY: begin
          if (cnt == '0) begin
            par_sh <= rx_s;
            cnt    <= BIT_LOAD;
            state  <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        STOP: begin
          if (cnt == '0) begin
            // Deliver even on a bad stop bit; frm_err qualifies the frame.
            state   <= IDLE;
            busy    <= 1'b0;
            data    <= data_sh;
            par_bit <= par_sh;
            par_err <= ((^data_sh) ^ par_sh) != PAR_ODD;
            frm_err <= ~rx_s;
            valid   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
